// File: rtl/mc_controller_pkg.sv
// Shared types for the multi-cycle controller: states, opcodes, encodings.
// Control word bundle plus dispatch and reset-gating helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMM_EX  = 4'd9,
    S_IMM_WB  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] MT_ALUOUT = 2'b00;
  localparam logic [1:0] MT_MDR    = 2'b01;
  localparam logic [1:0] MT_PC     = 2'b10;

  localparam logic [1:0] IN2_B     = 2'b00;
  localparam logic [1:0] IN2_FOUR  = 2'b01;
  localparam logic [1:0] IN2_IMM   = 2'b10;
  localparam logic [1:0] IN2_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       id_sel;
    logic       ir_we;
    logic       pc_we;
    logic       dm_we;
    logic       rf_we;
    logic       branch;
    logic       branch_ne;
    logic       rfd_sel;
    logic       rf_a3_ra;
    logic [1:0] mtorf_sel;
    logic       alu_in1_sel;
    logic [1:0] alu_in2_sel;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic [1:0] pc_sel;
    logic       instr_done;
  } ctrl_t;

  function automatic state_e dispatch(
    input logic [5:0] op
  );
    state_e s;
    s = S_ILLEGAL;
    unique case (1'b1)
      (op == OP_LW) || (op == OP_SW):
        s = S_MEMADR;
      op == OP_RTYPE:
        s = S_EXEC;
      (op == OP_BEQ) || (op == OP_BNE):
        s = S_BRANCH;
      (op == OP_ADDI) || (op == OP_ANDI)
        || (op == OP_ORI) || (op == OP_SLTI):
        s = S_IMM_EX;
      op == OP_J:
        s = S_JUMP;
      op == OP_JAL:
        s = S_JAL;
      default:
        s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  // Anything that commits state or talks to memory is held off in reset.
  function automatic ctrl_t rst_gate(
    input ctrl_t c
  );
    ctrl_t g;
    g            = c;
    g.mem_req    = 1'b0;
    g.ir_we      = 1'b0;
    g.pc_we      = 1'b0;
    g.dm_we      = 1'b0;
    g.rf_we      = 1'b0;
    g.branch     = 1'b0;
    g.branch_ne  = 1'b0;
    g.instr_done = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle; master = controller side.
// MC_CTRL_TRAP_EN adds the illegal_op status line.
interface mc_controller_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                id_sel;
  logic                ir_we;
  logic                pc_we;
  logic                dm_we;
  logic                rf_we;
  logic                branch;
  logic                branch_ne;
  logic                rfd_sel;
  logic                rf_a3_ra;
  logic [1:0]          mtorf_sel;
  logic                alu_in1_sel;
  logic [1:0]          alu_in2_sel;
  logic                imm_zext;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_sel;
  logic                instr_done;
  logic [3:0]          state_o;
`ifdef MC_CTRL_TRAP_EN
  logic                illegal_op;
`endif

  modport master (
`ifdef MC_CTRL_TRAP_EN
    output illegal_op,
`endif
    input  opcode, mem_ready,
    output mem_req, id_sel,
    output ir_we, pc_we, dm_we, rf_we,
    output branch, branch_ne,
    output rfd_sel, rf_a3_ra, mtorf_sel,
    output alu_in1_sel, alu_in2_sel,
    output imm_zext, alu_op, pc_sel,
    output instr_done, state_o
  );

  modport slave (
`ifdef MC_CTRL_TRAP_EN
    input  illegal_op,
`endif
    output opcode, mem_ready,
    input  mem_req, id_sel,
    input  ir_we, pc_we, dm_we, rf_we,
    input  branch, branch_ne,
    input  rfd_sel, rf_a3_ra, mtorf_sel,
    input  alu_in1_sel, alu_in2_sel,
    input  imm_zext, alu_op, pc_sel,
    input  instr_done, state_o
  );
endinterface

// File: rtl/mc_controller_outdec.sv
// Control word decode from current state, opcode and mem_ready.
// MC_CTRL_TRAP_EN: ILLEGAL drives nothing; otherwise it retires as a NOP.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req     = 1'b1;
        ctrl_o.alu_in2_sel = IN2_FOUR;
        ctrl_o.alu_op      = ALU_ADD;
        ctrl_o.pc_sel      = PC_ALU;
        ctrl_o.ir_we       = mem_ready_i;
        ctrl_o.pc_we       = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_in2_sel = IN2_IMMSH;
        ctrl_o.alu_op      = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_in1_sel = 1'b1;
        ctrl_o.alu_in2_sel = IN2_IMM;
        ctrl_o.alu_op      = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.id_sel  = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.mtorf_sel  = MT_MDR;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.id_sel     = 1'b1;
        ctrl_o.dm_we      = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_in1_sel = 1'b1;
        ctrl_o.alu_in2_sel = IN2_B;
        ctrl_o.alu_op      = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.rfd_sel    = 1'b1;
        ctrl_o.mtorf_sel  = MT_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_in1_sel = 1'b1;
        ctrl_o.alu_in2_sel = IN2_B;
        ctrl_o.alu_op      = ALU_SUB;
        ctrl_o.pc_sel      = PC_ALUOUT;
        ctrl_o.instr_done  = 1'b1;
        ctrl_o.branch      = (opcode_i == OP_BEQ);
        ctrl_o.branch_ne   = (opcode_i == OP_BNE);
      end
      S_IMM_EX: begin
        ctrl_o.alu_in1_sel = 1'b1;
        ctrl_o.alu_in2_sel = IN2_IMM;
        unique case (1'b1)
          opcode_i == OP_ANDI: begin
            ctrl_o.alu_op   = ALU_AND;
            ctrl_o.imm_zext = 1'b1;
          end
          opcode_i == OP_ORI: begin
            ctrl_o.alu_op   = ALU_OR;
            ctrl_o.imm_zext = 1'b1;
          end
          opcode_i == OP_SLTI:
            ctrl_o.alu_op = ALU_SLT;
          default:
            ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      S_IMM_WB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.mtorf_sel  = MT_ALUOUT;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_sel     = PC_JUMP;
        ctrl_o.pc_we      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      // PC already holds PC+4 here, so it is the link value.
      S_JAL: begin
        ctrl_o.pc_sel     = PC_JUMP;
        ctrl_o.pc_we      = 1'b1;
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.rf_a3_ra   = 1'b1;
        ctrl_o.mtorf_sel  = MT_PC;
        ctrl_o.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
`ifndef MC_CTRL_TRAP_EN
        ctrl_o.instr_done = 1'b1;
`endif
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset main controller: state register and sequencing.
// MC_CTRL_TRAP_EN makes ILLEGAL absorbing and exposes illegal_op.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input logic             clk,
  input logic             rst,
  mc_controller_if.master bus
);

  state_e              state_q;
  state_e              state_d;
  logic [OPCODE_W-1:0] opc;
  logic [5:0]          op;
  ctrl_t               ctrl;
  ctrl_t               ctrl_g;

  assign opc = bus.opcode;
  assign op  = opc[5:0];

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        state_d = dispatch(op);
      S_MEMADR: begin
        if (op == OP_SW)
          state_d = S_MEMWR;
        else if (op == OP_LW)
          state_d = S_MEMRD;
        else
          state_d = S_FETCH;
      end
      S_MEMRD:
        state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:
        state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:
        state_d = S_ALUWB;
      S_IMM_EX:
        state_d = S_IMM_WB;
`ifdef MC_CTRL_TRAP_EN
      S_ILLEGAL:
        state_d = S_ILLEGAL;
`endif
      default:
        state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .opcode_i    (op),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign ctrl_g = rst ? rst_gate(ctrl) : ctrl;

  assign bus.mem_req     = ctrl_g.mem_req;
  assign bus.id_sel      = ctrl_g.id_sel;
  assign bus.ir_we       = ctrl_g.ir_we;
  assign bus.pc_we       = ctrl_g.pc_we;
  assign bus.dm_we       = ctrl_g.dm_we;
  assign bus.rf_we       = ctrl_g.rf_we;
  assign bus.branch      = ctrl_g.branch;
  assign bus.branch_ne   = ctrl_g.branch_ne;
  assign bus.rfd_sel     = ctrl_g.rfd_sel;
  assign bus.rf_a3_ra    = ctrl_g.rf_a3_ra;
  assign bus.mtorf_sel   = ctrl_g.mtorf_sel;
  assign bus.alu_in1_sel = ctrl_g.alu_in1_sel;
  assign bus.alu_in2_sel = ctrl_g.alu_in2_sel;
  assign bus.imm_zext    = ctrl_g.imm_zext;
  assign bus.alu_op      = ALUOP_W'(ctrl_g.alu_op);
  assign bus.pc_sel      = ctrl_g.pc_sel;
  assign bus.instr_done  = ctrl_g.instr_done;
  assign bus.state_o     = state_q;

`ifdef MC_CTRL_TRAP_EN
  assign bus.illegal_op  = (state_q == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller.
// Also covers the MC_CTRL_TRAP_EN build when that macro is defined.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  mc_controller_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

  mc_controller #(
    .OPCODE_W (6),
    .ALUOP_W  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [25:0] exp;
    logic        ill;
  } vec_t;

  vec_t q[$];

  function automatic logic [25:0] cw(
    input logic [3:0] st,
    input logic rq, id, ir, pc, dm, rf,
    input logic br, bn, rd, ra,
    input logic [1:0] mt,
    input logic i1,
    input logic [1:0] i2,
    input logic zx,
    input logic [2:0] al,
    input logic [1:0] ps,
    input logic dn
  );
    return {st, rq, id, ir, pc, dm, rf, br, bn,
            rd, ra, mt, i1, i2, zx, al, ps, dn};
  endfunction

  function automatic logic [25:0] act();
    return {bus.state_o, bus.mem_req, bus.id_sel,
            bus.ir_we, bus.pc_we, bus.dm_we, bus.rf_we,
            bus.branch, bus.branch_ne, bus.rfd_sel,
            bus.rf_a3_ra, bus.mtorf_sel, bus.alu_in1_sel,
            bus.alu_in2_sel, bus.imm_zext, bus.alu_op,
            bus.pc_sel, bus.instr_done};
  endfunction

  task automatic add(
    input logic r,
    input logic [5:0] o,
    input logic m,
    input logic [25:0] e,
    input logic il
  );
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.exp = e; v.ill = il;
    q.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic step(
    input logic r,
    input logic [5:0] o,
    input logic m
  );
    @(negedge clk);
    rst = r;
    bus.opcode = o;
    bus.mem_ready = m;
    #1;
  endtask

  logic [25:0] F_RST, F_STL, F_GO, DEC;

  task automatic fetch_dec(input logic [5:0] o, input logic m);
    add(0, o, 1, F_GO, 0);
    add(0, o, m, DEC, 0);
  endtask

  initial begin
    int dn;
    int we;
    rst = 1'b1;
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b0;

    F_RST = cw(S_FETCH,0,0,0,0,0,0,0,0,0,0,
               2'b00,0,2'b01,0,3'b000,2'b00,0);
    F_STL = cw(S_FETCH,1,0,0,0,0,0,0,0,0,0,
               2'b00,0,2'b01,0,3'b000,2'b00,0);
    F_GO  = cw(S_FETCH,1,0,1,1,0,0,0,0,0,0,
               2'b00,0,2'b01,0,3'b000,2'b00,0);
    DEC   = cw(S_DECODE,0,0,0,0,0,0,0,0,0,0,
               2'b00,0,2'b11,0,3'b000,2'b00,0);

    // reset and fetch stall
    add(1, OP_LW, 0, F_RST, 0);
    add(1, OP_LW, 1, F_RST, 0);
    add(0, OP_LW, 0, F_STL, 0);
    add(0, OP_LW, 0, F_STL, 0);
    add(0, OP_LW, 0, F_STL, 0);
    // lw with two-cycle data wait
    fetch_dec(OP_LW, 0);
    add(0, OP_LW, 0, cw(S_MEMADR,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,0,3'b000,2'b00,0), 0);
    add(0, OP_LW, 0, cw(S_MEMRD,1,1,0,0,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,0), 0);
    add(0, OP_LW, 1, cw(S_MEMRD,1,1,0,0,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,0), 0);
    add(0, OP_LW, 0, cw(S_MEMWB,0,0,0,0,0,1,0,0,0,0,
        2'b01,0,2'b00,0,3'b000,2'b00,1), 0);
    // sw aborted by reset in second MEMWR cycle
    fetch_dec(OP_SW, 0);
    add(0, OP_SW, 0, cw(S_MEMADR,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,0,3'b000,2'b00,0), 0);
    add(0, OP_SW, 0, cw(S_MEMWR,1,1,0,0,1,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,0), 0);
    add(1, OP_SW, 1, cw(S_MEMWR,0,1,0,0,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,0), 0);
    // bne / beq
    fetch_dec(OP_BNE, 0);
    add(0, OP_BNE, 0, cw(S_BRANCH,0,0,0,0,0,0,0,1,0,0,
        2'b00,1,2'b00,0,3'b001,2'b01,1), 0);
    fetch_dec(OP_BEQ, 0);
    add(0, OP_BEQ, 1, cw(S_BRANCH,0,0,0,0,0,0,1,0,0,0,
        2'b00,1,2'b00,0,3'b001,2'b01,1), 0);
    // immediates; mem_ready ignored in DECODE/IMM states
    fetch_dec(OP_ORI, 1);
    add(0, OP_ORI, 1, cw(S_IMM_EX,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,1,3'b100,2'b00,0), 0);
    add(0, OP_ORI, 1, cw(S_IMM_WB,0,0,0,0,0,1,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
    fetch_dec(OP_ANDI, 0);
    add(0, OP_ANDI, 0, cw(S_IMM_EX,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,1,3'b011,2'b00,0), 0);
    add(0, OP_ANDI, 0, cw(S_IMM_WB,0,0,0,0,0,1,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
    fetch_dec(OP_ADDI, 0);
    add(0, OP_ADDI, 0, cw(S_IMM_EX,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,0,3'b000,2'b00,0), 0);
    add(0, OP_ADDI, 0, cw(S_IMM_WB,0,0,0,0,0,1,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
    fetch_dec(OP_SLTI, 0);
    add(0, OP_SLTI, 0, cw(S_IMM_EX,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b10,0,3'b101,2'b00,0), 0);
    add(0, OP_SLTI, 0, cw(S_IMM_WB,0,0,0,0,0,1,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
    // R-type
    fetch_dec(OP_RTYPE, 0);
    add(0, OP_RTYPE, 1, cw(S_EXEC,0,0,0,0,0,0,0,0,0,0,
        2'b00,1,2'b00,0,3'b010,2'b00,0), 0);
    add(0, OP_RTYPE, 0, cw(S_ALUWB,0,0,0,0,0,1,0,0,1,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
    // jal / j
    fetch_dec(OP_JAL, 1);
    add(0, OP_JAL, 1, cw(S_JAL,0,0,0,1,0,1,0,0,0,1,
        2'b10,0,2'b00,0,3'b000,2'b10,1), 0);
    fetch_dec(OP_J, 0);
    add(0, OP_J, 0, cw(S_JUMP,0,0,0,1,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b10,1), 0);
    // illegal opcode
    fetch_dec(6'b111111, 0);
`ifdef MC_CTRL_TRAP_EN
    for (int k = 0; k < 10; k++)
      add(0, 6'b111111, 1, cw(S_ILLEGAL,0,0,0,0,0,0,0,0,0,0,
          2'b00,0,2'b00,0,3'b000,2'b00,0), 1);
    add(1, 6'b111111, 0, cw(S_ILLEGAL,0,0,0,0,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,0), 1);
`else
    add(0, 6'b111111, 0, cw(S_ILLEGAL,0,0,0,0,0,0,0,0,0,0,
        2'b00,0,2'b00,0,3'b000,2'b00,1), 0);
`endif
    add(0, OP_LW, 0, F_STL, 0);

    foreach (q[i]) begin
      step(q[i].rst, q[i].op, q[i].mr);
      chk($sformatf("vec%0d", i), 32'(act()), 32'(q[i].exp));
`ifdef MC_CTRL_TRAP_EN
      chk($sformatf("ill%0d", i), 32'(bus.illegal_op),
          32'(q[i].ill));
`endif
    end

    // lw with a five-cycle memory wait: one done, one rf write
    dn = 0;
    we = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, OP_LW, (k == 0) || (k == 8));
      dn += int'(bus.instr_done);
      we += int'(bus.rf_we);
    end
    step(0, OP_LW, 0);
    chk("lw_wait_end", 32'(bus.state_o), 32'(S_FETCH));
    chk("lw_wait_done", dn, 1);
    chk("lw_wait_rfwe", we, 1);

    // sw held three MEMWR cycles: dm_we each cycle, done once
    dn = 0;
    we = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, OP_SW, k == 0 || k == 5);
      dn += int'(bus.instr_done);
      we += int'(bus.dm_we);
    end
    step(0, OP_SW, 0);
    chk("sw_wait_end", 32'(bus.state_o), 32'(S_FETCH));
    chk("sw_wait_done", dn, 1);
    chk("sw_wait_dmwe", we, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
